// File: rtl/cpu_pkg.sv
// Shared datapath constants and the divider state encoding.
// Used by divider_16bit, its bus interface and the trial subtractor.
package cpu_pkg;

  localparam int WIDTH     = 16;
  localparam int DIV_STEPS = 16;
  localparam int CNT_W     = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage : cpu_pkg

// File: rtl/divider_16bit_if.sv
// Start/Done handshake bundle between the datapath (master) and the divider (slave).
interface divider_16bit_if import cpu_pkg::*;;

  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivZero;

  modport master (
    output Start, Dividend, Divisor,
    input  Busy, Done, Quotient, Remainder, DivZero
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Busy, Done, Quotient, Remainder, DivZero
  );

endinterface : divider_16bit_if

// File: rtl/sub_stage_17bit.sv
// Combinational 17-bit trial subtractor for one restoring-division step.
// borrow_o is bit 16 of the 17-bit difference; diff_o holds the low 16 bits.
module sub_stage_17bit (
  input  logic [16:0] minuend_i,
  input  logic [16:0] subtrahend_i,
  output logic [15:0] diff_o,
  output logic        borrow_o
);

  assign {borrow_o, diff_o} = minuend_i - subtrahend_i;

endmodule : sub_stage_17bit

// File: rtl/divider_16bit.sv
// Multi-cycle unsigned 16-bit restoring divider, one quotient bit per clock.
// Optional macro DIVIDER_DIVZERO_DETECT_EN short-cuts a zero divisor to DONE and raises DivZero.
module divider_16bit
  import cpu_pkg::*;
(
  input  logic            Clock,
  input  logic            ResetN,
  divider_16bit_if.slave  div_if
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  // Partial remainder stays below the divisor between steps, so its 17th bit
  // is always zero at rest and only the low 16 bits need a register.
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;

  sub_stage_17bit u_sub_stage (
    .minuend_i    ({r_q, q_q[WIDTH-1]}),
    .subtrahend_i ({1'b0, d_q}),
    .diff_o       (trial_diff),
    .borrow_o     (trial_borrow)
  );

`ifdef DIVIDER_DIVZERO_DETECT_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIVIDER_DIVZERO_DETECT_EN
    dz_d    = dz_q;
`endif

    unique case (state_q)
      DIV_IDLE: begin
        if (div_if.Start) begin
          q_d     = div_if.Dividend;
          d_d     = div_if.Divisor;
          r_d     = '0;
          cnt_d   = '0;
          quot_d  = '0;
          rem_d   = '0;
          state_d = DIV_RUN;
`ifdef DIVIDER_DIVZERO_DETECT_EN
          dz_d    = 1'b0;
          if (div_if.Divisor == '0) begin
            quot_d  = '1;
            rem_d   = div_if.Dividend;
            dz_d    = 1'b1;
            state_d = DIV_DONE;
          end
`endif
        end
      end

      DIV_RUN: begin
        if (!trial_borrow) begin
          r_d = trial_diff;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          quot_d  = q_d;
          rem_d   = r_d;
          state_d = DIV_DONE;
        end
      end

      DIV_DONE: state_d = DIV_IDLE;

      default:  state_d = DIV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= DIV_IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

`ifdef DIVIDER_DIVZERO_DETECT_EN
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) dz_q <= 1'b0;
    else         dz_q <= dz_d;
  end

  assign div_if.DivZero = dz_q;
`else
  assign div_if.DivZero = 1'b0;
`endif

  assign div_if.Busy      = (state_q != DIV_IDLE);
  assign div_if.Done      = (state_q == DIV_DONE);
  assign div_if.Quotient  = quot_q;
  assign div_if.Remainder = rem_q;

endmodule : divider_16bit

// File: tb/tb_divider_16bit.sv
// Directed self-checking bench for divider_16bit: latency, results, held outputs,
// ignored Start while busy, divide-by-zero (both builds) and mid-run reset abort.
`timescale 1ns/1ps
module tb_divider_16bit;
  import cpu_pkg::*;

  logic Clock;
  logic ResetN;
  int   n_checks = 0;
  int   n_errors = 0;

  divider_16bit_if div_if ();

  divider_16bit dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .div_if (div_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands at a falling edge; the following rising edge accepts them.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge Clock);
    div_if.Start    = 1'b1;
    div_if.Dividend = a;
    div_if.Divisor  = b;
    @(posedge Clock);
    #1 div_if.Start = 1'b0;
  endtask

  // Counts falling edges after the accepting edge until Done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      lat++;
      if (div_if.Done) break;
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_q, input logic [15:0] exp_r,
                         input logic exp_dz, input int exp_lat);
    int lat;
    start_op(a, b);
    wait_done(lat);
    check({tag, " latency"},   lat,              exp_lat);
    check({tag, " quotient"},  div_if.Quotient,  {16'd0, exp_q});
    check({tag, " remainder"}, div_if.Remainder, {16'd0, exp_r});
    check({tag, " divzero"},   div_if.DivZero,   {31'd0, exp_dz});
    check({tag, " busy@done"}, div_if.Busy,      32'd1);
    @(negedge Clock);
    check({tag, " done 1 cycle"}, div_if.Done,   32'd0);
    check({tag, " busy after"},   div_if.Busy,   32'd0);
    check({tag, " q held"},       div_if.Quotient, {16'd0, exp_q});
  endtask

  initial begin
    int lat;
    int done_seen;

`ifdef DIVIDER_DIVZERO_DETECT_EN
    localparam int ZLAT = 1;
    localparam logic ZFLAG = 1'b1;
`else
    localparam int ZLAT = 17;
    localparam logic ZFLAG = 1'b0;
`endif

    ResetN          = 1'b0;
    div_if.Start    = 1'b0;
    div_if.Dividend = '0;
    div_if.Divisor  = '0;
    #2;
    check("reset busy", div_if.Busy,      32'd0);
    check("reset done", div_if.Done,      32'd0);
    check("reset quot", div_if.Quotient,  32'd0);
    check("reset rem",  div_if.Remainder, 32'd0);
    check("reset dz",   div_if.DivZero,   32'd0);
    @(negedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;

    run_div("100/7",     16'd100,   16'd7,  16'd14,    16'd2, 1'b0, 17);
    run_div("ffff/1",    16'hFFFF,  16'd1,  16'hFFFF,  16'd0, 1'b0, 17);
    run_div("40000/3",   16'd40000, 16'd3,  16'd13333, 16'd1, 1'b0, 17);
    run_div("5/10",      16'd5,     16'd10, 16'd0,     16'd5, 1'b0, 17);
    run_div("0/9",       16'd0,     16'd9,  16'd0,     16'd0, 1'b0, 17);
    run_div("1234/0",    16'd1234,  16'd0,  16'hFFFF,  16'd1234, ZFLAG, ZLAT);

    // Start re-pulsed while running must be ignored and not queued.
    start_op(16'd100, 16'd7);
    repeat (3) @(negedge Clock);
    check("run busy",          div_if.Busy,     32'd1);
    check("run quot cleared",  div_if.Quotient, 32'd0);
    check("run dz cleared",    div_if.DivZero,  32'd0);
    div_if.Start    = 1'b1;
    div_if.Dividend = 16'd50;
    div_if.Divisor  = 16'd5;
    @(negedge Clock);
    div_if.Start = 1'b0;
    lat = 4;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      lat++;
      if (div_if.Done) break;
    end
    check("ignore latency", lat,              32'd17);
    check("ignore quot",    div_if.Quotient,  32'd14);
    check("ignore rem",     div_if.Remainder, 32'd2);

    // Start held through the DONE cycle is accepted only once the state is IDLE.
    div_if.Start = 1'b1;
    @(negedge Clock);
    check("start in done ignored", div_if.Busy, 32'd0);
    @(posedge Clock);
    #1 div_if.Start = 1'b0;
    wait_done(lat);
    check("b2b latency", lat,              32'd17);
    check("b2b quot",    div_if.Quotient,  32'd10);
    check("b2b rem",     div_if.Remainder, 32'd0);
    @(negedge Clock);

    // Reset during iteration 8 aborts the division with no Done afterwards.
    start_op(16'd100, 16'd7);
    repeat (8) @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check("abort busy", div_if.Busy,      32'd0);
    check("abort done", div_if.Done,      32'd0);
    check("abort quot", div_if.Quotient,  32'd0);
    check("abort rem",  div_if.Remainder, 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clock);
      if (div_if.Done) done_seen++;
    end
    check("abort no done", done_seen, 32'd0);
    run_div("9/3 after reset", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_divider_16bit

// File: doc/divider_16bit.md
# divider_16bit

Multi-cycle unsigned 16-bit divider: subtraction-based counterpart to the 16-bit adder in the single-cycle datapath. It computes `Quotient = Dividend / Divisor` and `Remainder = Dividend % Divisor` by restoring division, one quotient bit per clock. Operands and results move through a Start/Done handshake. It serves as a slow co-unit beside the ALU, with the datapath stalling on `Busy`.

## Interface
- `WIDTH`, 16, operand and result width; only 16 is supported.
- `Clock`  in  1  rising-edge clock.
- `ResetN`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request; sampled only in IDLE.
- `Dividend`  in  16  unsigned numerator; sampled on the accepting edge.
- `Divisor`  in  16  unsigned denominator; sampled on the accepting edge.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `Done`  out  1  one-cycle pulse when results become valid.
- `Quotient`  out  16  registered result; held until the next accepted Start.
- `Remainder`  out  16  registered result; held until the next accepted Start.
- `DivZero`  out  1  divisor-was-zero flag; held with the results.

## Operation
- States: IDLE, RUN, DONE. Encoding lives in the package.
- IDLE
  - On an edge with `Start=1`: latch Dividend into Q shift register `q`, latch Divisor into `d`, clear 17-bit partial remainder `r`, set `cnt=0`, go to RUN.
  - Clear `Quotient`, `Remainder` and `DivZero` on acceptance.
- RUN, each edge performs one iteration:
  - `trial = {r[15:0], q[15]} - {1'b0, d}`, computed as a 17-bit subtract.
  - `trial[16]=0` (no borrow): `r ← trial`, `q ← {q[14:0], 1}`.
  - Otherwise: `r ← {r[15:0], q[15]}`, `q ← {q[14:0], 0}`.
  - `cnt` increments. After the iteration with `cnt=15`, register `Quotient ← q`, `Remainder ← r[15:0]`, and go to DONE.
- DONE: `Done=1` for exactly this cycle, then IDLE.
- `Start` in RUN or DONE is ignored and is not queued.
- All arithmetic is unsigned with no overflow possible. `Remainder < Divisor` whenever `Divisor ≠ 0`.
- Divisor zero without the feature macro: the natural result is `Quotient=0xFFFF`, `Remainder=Dividend`, `DivZero=0`.

## Timing
- Reset (async assert, sync release) forces state IDLE and `Busy=0`, `Done=0`, `Quotient=0`, `Remainder=0`, `DivZero=0`. Internal `q`, `r`, `d` and `cnt` are cleared.
- Latency: Start accepted at edge N → RUN on edges N+1..N+16 → `Done` high in the cycle after edge N+16. Results are valid from that same edge.
- `Busy` rises the cycle after edge N and falls with the end of `Done`. A new Start is accepted at the first edge where the state is IDLE, i.e. edge N+18.
- Back-to-back throughput: one division every 18 cycles.
- Reset asserted mid-RUN aborts the operation. `Done` never pulses for the aborted request.

## Configuration
- `DIVIDER_DIVZERO_DETECT_EN` defined:
  - Start with `Divisor=0` goes IDLE → DONE directly.
  - `Done` pulses on the cycle after the accepting edge.
  - Outputs: `Quotient=0xFFFF`, `Remainder=Dividend`, `DivZero=1`.
- Not defined:
  - The full 16-iteration path runs.
  - `DivZero` is tied to 0.
  - Numeric results are identical to the defined case.

## Structure
- Shared package `cpu_pkg` holds:
  - `WIDTH=16`.
  - The state encoding constants `DIV_IDLE`, `DIV_RUN`, `DIV_DONE`.
  - The iteration count constant `DIV_STEPS=16`.
- Sub-module `sub_stage_17bit`: combinational 17-bit trial subtractor, outputs difference and borrow. It is instantiated once in `divider_16bit`.
- Counter, FSM and shift registers stay in the top module.

## Test plan
- Dividend=100, Divisor=7, Start pulse → after 17 cycles `Done`=1, Quotient=14, Remainder=2, Busy low the next cycle.
- Dividend=0xFFFF, Divisor=1 → Quotient=0xFFFF, Remainder=0. Dividend=40000, Divisor=3 → Quotient=13333, Remainder=1.
- Dividend=5, Divisor=10 → Quotient=0, Remainder=5. Dividend=0, Divisor=9 → Quotient=0, Remainder=0.
- Dividend=1234, Divisor=0:
  - With the macro: Done 1 cycle after accept, Quotient=0xFFFF, Remainder=1234, DivZero=1.
  - Without the macro: Done after 17 cycles, same numbers, DivZero=0.
- Start re-pulsed with Dividend=50, Divisor=5 during RUN of 100/7 → ignored; results are still 14/2. A Start at IDLE right after Done → 10/0.
- ResetN pulled low at iteration 8 of 100/7 → all outputs 0 immediately. No Done pulse afterwards. A fresh 9/3 after release → Quotient=3, Remainder=0.
